exe_alu_unit: RTL and testbench

- Execute-stage datapath of the 5-stage MIPS-style pipeline.
- Selects ALU operands through forwarding muxes, sign- or zero-extends the 16-bit immediate, picks the destination register, and computes result and branch flags combinationally.
- Holds the 64-bit multiply product in a clocked register.

---
 rtl/exe_alu_unit.sv | 124 ++++++++++++
 tb/tb_exe_alu_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_unit.sv
// Execute stage: forwarding muxes, immediate extension, ALU, branch flags.
// Optional EXE_MULT_EN builds the registered signed 32x32 multiplier.
module exe_alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] imm16_in,
    input  logic [31:0] busA_in,
    input  logic [31:0] busB_in,
    input  logic [31:0] Result_from_mem,
    input  logic [31:0] Result_from_wr,
    input  logic [31:0] pre_PC,
    input  logic [4:0]  shf,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic        RegDst_in,
    input  logic [1:0]  ALUSrc_A,
    input  logic [1:0]  ALUSrc_B,
    input  logic        ExtOp_in,
    input  logic [4:0]  ALUCtr_in,
    input  logic        mult_in,
    output logic [4:0]  rw,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Overflow,
    output logic        Bgez,
    output logic        Bgtz,
    output logic [63:0] mult_result
);

    logic [31:0] imm32;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        ovf_add;
    logic        ovf_sub;

    assign rw    = RegDst_in ? rd_in : rt_in;
    assign imm32 = ExtOp_in ? {{16{imm16_in[15]}}, imm16_in}
                            : {16'b0, imm16_in};

    always_comb begin
        a = busA_in;
        unique case (ALUSrc_A)
            2'b01:   a = Result_from_mem;
            2'b10:   a = Result_from_wr;
            default: a = busA_in;
        endcase
    end

    always_comb begin
        b = busB_in;
        unique case (ALUSrc_B)
            2'b01:   b = Result_from_mem;
            2'b10:   b = Result_from_wr;
            2'b11:   b = imm32;
            default: b = busB_in;
        endcase
    end

    assign sum  = a + b;
    assign diff = a - b;

    // Signed overflow: operand signs vs. result sign
    assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
    assign ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);

    always_comb begin
        Result   = 32'b0;
        Overflow = 1'b0;
        case (ALUCtr_in)
            5'd0:  Result = sum;
            5'd1: begin
                Result   = sum;
                Overflow = ovf_add;
            end
            5'd2:  Result = diff;
            5'd3: begin
                Result   = diff;
                Overflow = ovf_sub;
            end
            5'd4:  Result = a & b;
            5'd5:  Result = a | b;
            5'd6:  Result = a ^ b;
            5'd7:  Result = ~(a | b);
            5'd8:  Result = {31'b0, $signed(a) < $signed(b)};
            5'd9:  Result = {31'b0, a < b};
            5'd10: Result = b << shf;
            5'd11: Result = b >> shf;
            5'd12: Result = $unsigned($signed(b) >>> shf);
            5'd13: Result = b << a[4:0];
            5'd14: Result = b >> a[4:0];
            5'd15: Result = $unsigned($signed(b) >>> a[4:0]);
            5'd16: Result = {b[15:0], 16'b0};
            5'd17: Result = pre_PC + 32'd8;
            default: Result = 32'b0;
        endcase
    end

    assign Zero = (a == b);
    assign Bgez = ~a[31];
    assign Bgtz = ~a[31] & (a != 32'b0);

`ifdef EXE_MULT_EN
    logic [63:0] product;

    // Low 64 bits of the sign-extended operands give the signed product
    assign product = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_result <= 64'h0;
        end else if (mult_in) begin
            mult_result <= product;
        end
    end
`else
    logic unused_mult;

    assign unused_mult = &{1'b0, clk, rst, mult_in};
    assign mult_result = 64'h0;
`endif

endmodule

// File: tb/tb_exe_alu_unit.sv
// Scoreboard bench for exe_alu_unit: directed plan vectors plus random
// vectors checked against a behavioural model.
module tb_exe_alu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imm16_in = '0;
    logic [31:0] busA_in = '0;
    logic [31:0] busB_in = '0;
    logic [31:0] Result_from_mem = '0;
    logic [31:0] Result_from_wr = '0;
    logic [31:0] pre_PC = '0;
    logic [4:0]  shf = '0;
    logic [4:0]  rt_in = '0;
    logic [4:0]  rd_in = '0;
    logic        RegDst_in = 1'b0;
    logic [1:0]  ALUSrc_A = '0;
    logic [1:0]  ALUSrc_B = '0;
    logic        ExtOp_in = 1'b0;
    logic [4:0]  ALUCtr_in = '0;
    logic        mult_in = 1'b0;
    logic [4:0]  rw;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        Bgez;
    logic        Bgtz;
    logic [63:0] mult_result;

    exe_alu_unit dut (
        .clk(clk), .rst(rst), .imm16_in(imm16_in),
        .busA_in(busA_in), .busB_in(busB_in),
        .Result_from_mem(Result_from_mem),
        .Result_from_wr(Result_from_wr), .pre_PC(pre_PC),
        .shf(shf), .rt_in(rt_in), .rd_in(rd_in),
        .RegDst_in(RegDst_in), .ALUSrc_A(ALUSrc_A),
        .ALUSrc_B(ALUSrc_B), .ExtOp_in(ExtOp_in),
        .ALUCtr_in(ALUCtr_in), .mult_in(mult_in),
        .rw(rw), .Result(Result), .Zero(Zero),
        .Overflow(Overflow), .Bgez(Bgez), .Bgtz(Bgtz),
        .mult_result(mult_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] imm;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] mem;
        logic [31:0] wr;
        logic [31:0] pc;
        logic [4:0]  shf;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regdst;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic        ext;
        logic [4:0]  op;
        logic        mul;
    } vec_t;

    typedef struct {
        int          id;
        logic [4:0]  rw;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ge;
        logic        gt;
        logic [63:0] mr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_vec = 0;
    logic [63:0] model_mult = 64'h0;

    function automatic logic [31:0] opnd_a(vec_t v);
        if (v.sel_a == 2'd1) return v.mem;
        if (v.sel_a == 2'd2) return v.wr;
        return v.bus_a;
    endfunction

    function automatic logic [31:0] opnd_b(vec_t v);
        longint iv;
        if (v.sel_b == 2'd1) return v.mem;
        if (v.sel_b == 2'd2) return v.wr;
        if (v.sel_b == 2'd0) return v.bus_b;
        iv = v.ext ? longint'($signed(v.imm)) : longint'(v.imm);
        return iv[31:0];
    endfunction

    function automatic exp_t model(vec_t v);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      r;
        a  = opnd_a(v);
        b  = opnd_b(v);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = 0;
        e.ovf = 1'b0;
        case (int'(v.op))
            0: r = ua + ub;
            1: begin
                r = sa + sb;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            2: r = ua - ub;
            3: begin
                r = sa - sb;
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4: r = ua & ub;
            5: r = ua | ub;
            6: r = ua ^ ub;
            7: r = ~(ua | ub);
            8: r = (sa < sb) ? 1 : 0;
            9: r = (ua < ub) ? 1 : 0;
            10: r = ub * (longint'(1) << v.shf);
            11: r = ub / (longint'(1) << v.shf);
            12: r = sb >>> v.shf;
            13: r = ub * (longint'(1) << a[4:0]);
            14: r = ub / (longint'(1) << a[4:0]);
            15: r = sb >>> a[4:0];
            16: r = (ub % 65536) * 65536;
            17: r = longint'(v.pc) + 8;
            default: r = 0;
        endcase
        e.res  = r[31:0];
        e.rw   = v.regdst ? v.rd : v.rt;
        e.zero = (a == b);
        e.ge   = (sa >= 0);
        e.gt   = (sa > 0);
        e.id   = n_vec;
        return e;
    endfunction

    task automatic go(input vec_t v);
        exp_t        e;
        logic [63:0] prod;
        @(posedge clk);
        #1;
        rst = v.rst; imm16_in = v.imm;
        busA_in = v.bus_a; busB_in = v.bus_b;
        Result_from_mem = v.mem; Result_from_wr = v.wr;
        pre_PC = v.pc; shf = v.shf; rt_in = v.rt; rd_in = v.rd;
        RegDst_in = v.regdst; ALUSrc_A = v.sel_a;
        ALUSrc_B = v.sel_b; ExtOp_in = v.ext;
        ALUCtr_in = v.op; mult_in = v.mul;
        e = model(v);
        e.mr = v.rst ? 64'h0 : model_mult;
        sb_q.push_back(e);
        n_vec++;
        prod = 64'(longint'($signed(opnd_a(v)))
                   * longint'($signed(opnd_b(v))));
`ifdef EXE_MULT_EN
        if (v.rst) model_mult = 64'h0;
        else if (v.mul) model_mult = prod;
`else
        if (prod == 64'h1) model_mult = 64'h0;
`endif
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rw", e.id, 64'(rw), 64'(e.rw));
                chk("Result", e.id, 64'(Result), 64'(e.res));
                chk("Zero", e.id, 64'(Zero), 64'(e.zero));
                chk("Overflow", e.id, 64'(Overflow), 64'(e.ovf));
                chk("Bgez", e.id, 64'(Bgez), 64'(e.ge));
                chk("Bgtz", e.id, 64'(Bgtz), 64'(e.gt));
                chk("mult_result", e.id, mult_result, e.mr);
            end
        end
    end

    initial begin : stim
        vec_t d;
        vec_t v;
        int   wait_cyc;
        d = '{rst: 1'b0, imm: 16'h0, bus_a: 32'h0, bus_b: 32'h0,
              mem: 32'h0, wr: 32'h0, pc: 32'h0, shf: 5'd0,
              rt: 5'd0, rd: 5'd0, regdst: 1'b0, sel_a: 2'd0,
              sel_b: 2'd0, ext: 1'b0, op: 5'd0, mul: 1'b0};
        v = d; v.rst = 1'b1; go(v);
        v = d; v.sel_a = 2'd1; v.sel_b = 2'd3; v.ext = 1'b1;
        v.imm = 16'hFFFF; v.mem = 32'd5; go(v);
        v.ext = 1'b0; go(v);
        v = d; v.bus_a = 32'h7FFFFFFF; v.bus_b = 32'd1; v.op = 5'd1; go(v);
        v.op = 5'd0; go(v);
        v.bus_a = 32'h80000000; v.op = 5'd3; go(v);
        v = d; v.bus_a = 32'hFFFFFFFF; v.bus_b = 32'd1; v.op = 5'd8; go(v);
        v.op = 5'd9; go(v);
        v = d; v.bus_a = 32'd7; v.bus_b = 32'd7; v.op = 5'd6; go(v);
        v = d; v.bus_b = 32'h80000010; v.shf = 5'd4; v.op = 5'd11; go(v);
        v.op = 5'd12; go(v);
        v.op = 5'd10; go(v);
        v.bus_a = 32'd1; v.op = 5'd13; go(v);
        v.op = 5'd14; go(v);
        v.op = 5'd15; go(v);
        v = d; v.bus_b = 32'h1234; v.op = 5'd16; go(v);
        v = d; v.pc = 32'h00003000; v.op = 5'd17; go(v);
        v = d; v.regdst = 1'b1; v.rd = 5'd31; v.rt = 5'd3;
        v.op = 5'd20; v.bus_a = 32'h55; go(v);
        v = d; v.sel_a = 2'd2; v.wr = 32'hFFFFFFFD; v.bus_b = 32'd5;
        v.mul = 1'b1; go(v);
        v.mul = 1'b0; v.wr = 32'h1234; go(v);
        go(v);
        v.rst = 1'b1; v.mul = 1'b1; go(v);
        v.rst = 1'b0; v.mul = 1'b0; go(v);
        for (int i = 0; i < 400; i++) begin
            v.rst    = ($urandom_range(0, 19) == 0);
            v.imm    = 16'($urandom);
            v.bus_a  = $urandom;
            v.bus_b  = ($urandom_range(0, 7) == 0) ? v.bus_a : $urandom;
            v.mem    = $urandom;
            v.wr     = $urandom;
            v.pc     = $urandom;
            v.shf    = 5'($urandom);
            v.rt     = 5'($urandom);
            v.rd     = 5'($urandom);
            v.regdst = 1'($urandom);
            v.sel_a  = 2'($urandom);
            v.sel_b  = 2'($urandom);
            v.ext    = 1'($urandom);
            v.op     = 5'($urandom_range(0, 19));
            v.mul    = 1'($urandom);
            go(v);
        end
        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
